rgb_led_pwm: RTL and testbench

Downstream consumer of the core's GPIO/peripheral outputs on the Arty S7 FPGA top. It drives the board's two RGB LEDs (six channels: led0_r/g/b, led1_r/g/b) with independent 8-bit PWM duty cycles. Duty values are written over a valid/ready write port. Shadow registers commit only at PWM period boundaries, so brightness changes are glitch-free. Instantiated beside padctl; outputs go straight to the LED pads.

---
 rtl/rgb_led_pwm_pkg.sv | 23 ++
 rtl/rgb_led_pwm_chan.sv | 42 ++++
 rtl/rgb_led_pwm.sv | 94 +++++++++
 tb/tb_rgb_led_pwm.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pwm_pkg.sv
// Shared types and constants for the RGB LED PWM block.
// Board channel map: two RGB LEDs, three channels each.
package rgb_led_pwm_pkg;

  localparam int unsigned NumChan = 6;
  localparam int unsigned DutyW   = 8;

  typedef enum logic [2:0] {
    LED0_R = 3'd0,
    LED0_G = 3'd1,
    LED0_B = 3'd2,
    LED1_R = 3'd3,
    LED1_G = 3'd4,
    LED1_B = 3'd5
  } chan_e;

  typedef logic [DutyW-1:0] duty_t;

  function automatic logic off_level(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/rgb_led_pwm_chan.sv
// One PWM channel: shadow/active duty registers,
// counter compare and the registered pad drive.
module rgb_led_pwm_chan #(
  parameter int unsigned DutyW     = 8,
  parameter logic        ActiveLow = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic             commit_i,
  input  logic [DutyW-1:0] duty_i,
  input  logic [DutyW-1:0] cnt_i,
  output logic             led_o
);
  import rgb_led_pwm_pkg::*;

  logic [DutyW-1:0] shadow_q;
  logic [DutyW-1:0] active_q;
  logic             led_q;
  logic             led_d;

  assign led_d = (en_i && (cnt_i < active_q))
               ? ~off_level(ActiveLow)
               : off_level(ActiveLow);

  // commit samples the pre-write shadow value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= off_level(ActiveLow);
    end else begin
      if (wr_i) shadow_q <= duty_i;
      if (commit_i) active_q <= shadow_q;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// Six-channel RGB LED PWM: prescaler, period counter,
// duty write port and period-boundary commit.
module rgb_led_pwm #(
  parameter int unsigned NumChan     = 6,
  parameter int unsigned DutyW       = 8,
  parameter int unsigned PrescaleDiv = 256,
  parameter logic        ActiveLow   = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [2:0]         wr_chan_i,
  input  logic [DutyW-1:0]   wr_duty_i,
  output logic               wr_err_o,
  output logic               period_o,
  output logic [NumChan-1:0] led_o,
  output logic [NumChan-1:0] led_oe_o
);
  import rgb_led_pwm_pkg::*;

  localparam int unsigned PsW =
    (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PrescaleDiv - 1);

  logic [PsW-1:0]     psc_q, psc_d;
  logic [DutyW-1:0]   cnt_q, cnt_d;
  logic               rdy_q, err_q, per_q;
  logic [NumChan-1:0] oe_q;
  logic               tick, boundary;
  logic               wr_fire, chan_ok, commit;

  assign tick     = enable_i & (psc_q == PsMax);
  assign boundary = tick & (&cnt_q);
  assign wr_fire  = wr_valid_i & rdy_q;
  assign chan_ok  = {1'b0, wr_chan_i} < 4'(NumChan);
  // while disabled, writes go live immediately
  assign commit   = boundary | ~enable_i;

  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (!enable_i) begin
      psc_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      psc_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      psc_d = psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psc_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      per_q <= 1'b0;
      oe_q  <= '0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      rdy_q <= 1'b1;
      err_q <= wr_fire & ~chan_ok;
      per_q <= boundary;
      oe_q  <= '1;
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    rgb_led_pwm_chan #(
      .DutyW     (DutyW),
      .ActiveLow (ActiveLow)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (enable_i),
      .wr_i     (wr_fire & chan_ok & (wr_chan_i == 3'(c))),
      .commit_i (commit),
      .duty_i   (wr_duty_i),
      .cnt_i    (cnt_q),
      .led_o    (led_o[c])
    );
  end

  assign wr_ready_o = rdy_q;
  assign wr_err_o   = err_q;
  assign period_o   = per_q;
  assign led_oe_o   = oe_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: time-based reference model,
// directed period/duty scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_rgb_led_pwm;
  import rgb_led_pwm_pkg::*;

  localparam int PD  = 4;
  localparam int PER = 256 * PD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1, rst_al_n = 1'b1;
  logic       enable = 1'b0, wr_valid = 1'b0;
  logic [2:0] wr_chan = '0;
  duty_t      wr_duty = '0;
  logic       rdy, err, per;
  logic [5:0] led, oe;
  logic       rdy_al, err_al, per_al;
  logic [5:0] led_al, oe_al;

  int n_chk = 0, n_pass = 0;

  rgb_led_pwm #(.NumChan(6), .DutyW(8), .PrescaleDiv(PD),
                .ActiveLow(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .wr_valid_i(wr_valid), .wr_ready_o(rdy),
    .wr_chan_i(wr_chan), .wr_duty_i(wr_duty),
    .wr_err_o(err), .period_o(per),
    .led_o(led), .led_oe_o(oe));

  rgb_led_pwm #(.NumChan(6), .DutyW(8), .PrescaleDiv(PD),
                .ActiveLow(1'b1)) dut_al (
    .clk_i(clk), .rst_ni(rst_al_n), .enable_i(1'b1),
    .wr_valid_i(1'b0), .wr_ready_o(rdy_al),
    .wr_chan_i(3'd0), .wr_duty_i(8'd0),
    .wr_err_o(err_al), .period_o(per_al),
    .led_o(led_al), .led_oe_o(oe_al));

  // Reference model: position in the period is derived from the
  // number of enabled cycles, not from counter registers.
  int         en_t = 0;
  int         m_cnt;
  logic [7:0] shadow [6];
  logic [7:0] active [6];
  logic [5:0] m_led = '0;
  logic       m_per = 0, m_err = 0, m_rdy = 0, m_old_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_t = 0; m_led = '0; m_per = 0; m_err = 0; m_rdy = 0;
      for (int c = 0; c < 6; c++) begin
        shadow[c] = 0; active[c] = 0;
      end
    end else begin
      m_old_rdy = m_rdy;
      m_rdy = 1; m_err = 0; m_per = 0;
      if (enable) begin
        m_cnt = (en_t / PD) % 256;
        for (int c = 0; c < 6; c++) m_led[c] = (m_cnt < active[c]);
        m_per = ((en_t % PER) == PER - 1);
        en_t++;
        if (m_per)
          for (int c = 0; c < 6; c++) active[c] = shadow[c];
      end else begin
        m_led = '0; en_t = 0;
        for (int c = 0; c < 6; c++) active[c] = shadow[c];
      end
      if (wr_valid && m_old_rdy) begin
        if (wr_chan < 6) shadow[wr_chan] = wr_duty;
        else m_err = 1;
      end
    end
  end

  task automatic wr(input int ch, input int d);
    wr_valid = 1; wr_chan = 3'(ch); wr_duty = 8'(d);
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic wait_phase(input int ph, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * PER && !ok; i++)
      if ((en_t % PER) == ph) ok = 1;
      else @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1;
    #1 rst_n = 0; rst_al_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({led, oe, rdy, err, per} !== 15'h0)
      $display("FAIL reset_state: got %h want 0", {led, oe, rdy, err, per});
    else n_pass++;
    n_chk++;
    if ({led_al, oe_al} !== 12'hfc0)
      $display("FAIL reset_al: got %h want fc0", {led_al, oe_al});
    else n_pass++;
    rst_n = 1; rst_al_n = 1;
    @(negedge clk);
    n_chk++;
    if ({rdy, oe} !== 7'h7f)
      $display("FAIL ready_after_reset: got %h want 7f", {rdy, oe});
    else n_pass++;
    n_chk++;
    if ({rdy_al, oe_al, led_al} !== 13'h1fff)
      $display("FAIL al_after_reset: got %h want 1fff",
               {rdy_al, oe_al, led_al});
    else n_pass++;
  endtask

  task automatic test_idle();
    int last = -1, npulse = 0;
    logic [5:0] lit = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lit |= led;
      n_chk++;
      if ({led, per, err, rdy} !== {m_led, m_per, m_err, m_rdy})
        $display("FAIL idle_cycle: got %b want %b",
                 {led, per, err, rdy}, {m_led, m_per, m_err, m_rdy});
      else n_pass++;
      if (per) begin
        if (last >= 0) begin
          n_chk++;
          if (i - last != PER)
            $display("FAIL period_spacing: got %0d want %0d", i - last, PER);
          else n_pass++;
        end
        last = i; npulse++;
      end
    end
    n_chk++;
    if (npulse < 2 || lit !== 6'h0)
      $display("FAIL idle_summary: got pulses %0d lit %b want >=2 and 0",
               npulse, lit);
    else n_pass++;
  endtask

  task automatic test_mid_write();
    bit ok;
    int hi0 = 0, hio = 0;
    wait_phase(300, ok);
    wr(0, 64);
    for (int i = 0; i < 2 * PER && !per; i++) begin
      @(negedge clk);
      n_chk++;
      if ({led, per, err} !== {m_led, m_per, m_err})
        $display("FAIL mid_wait: got %b want %b",
                 {led, per, err}, {m_led, m_per, m_err});
      else n_pass++;
    end
    n_chk++;
    if (!ok || !per)
      $display("FAIL mid_boundary: got %0d want 1", ok && per);
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      hi0 += led[0];
      hio += (led[5:1] != 0);
    end
    n_chk++;
    if (hi0 != 256 || hio != 0)
      $display("FAIL duty64: got hi %0d others %0d want 256 0", hi0, hio);
    else n_pass++;
  endtask

  task automatic test_boundary_write();
    bit ok;
    int hi5a = 0, hi5b = 0, hi0 = 0;
    wait_phase(PER - 1, ok);
    wr(5, 200);
    n_chk++;
    if (!ok || per !== 1'b1)
      $display("FAIL bnd_pulse: got %b want 1", per);
    else n_pass++;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      hi5a += led[5];
      hi0  += led[0];
    end
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      hi5b += led[5];
      n_chk++;
      if (led !== m_led)
        $display("FAIL bnd_cycle: got %b want %b", led, m_led);
      else n_pass++;
    end
    n_chk++;
    if (hi5a != 0 || hi0 != 256)
      $display("FAIL bnd_old: got %0d %0d want 0 256", hi5a, hi0);
    else n_pass++;
    n_chk++;
    if (hi5b != 800)
      $display("FAIL duty200: got %0d want 800", hi5b);
    else n_pass++;
  endtask

  task automatic test_bad_chan();
    wr(7, 8'haa);
    n_chk++;
    if (err !== 1'b1)
      $display("FAIL err_pulse: got %b want 1", err);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0)
      $display("FAIL err_clear: got %b want 0", err);
    else n_pass++;
    for (int i = 0; i < PER + 50; i++) begin
      @(negedge clk);
      n_chk++;
      if ({led, err} !== {m_led, m_err})
        $display("FAIL bad_chan_cycle: got %b want %b",
                 {led, err}, {m_led, m_err});
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    int hi2 = 0;
    wr(2, 128);
    enable = 0;
    @(negedge clk);
    n_chk++;
    if (led !== 6'h0)
      $display("FAIL dis_off: got %b want 0", led);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if ({led, per} !== 7'h0)
        $display("FAIL dis_hold: got %b want 0", {led, per});
      else n_pass++;
    end
    enable = 1;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_chk++;
        if (led[2] !== 1'b1)
          $display("FAIL reen_first: got %b want 1", led[2]);
        else n_pass++;
      end
      hi2 += led[2];
    end
    n_chk++;
    if (hi2 != 512)
      $display("FAIL duty128: got %0d want 512", hi2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n_chk++;
      if ({led, per, err, rdy} !== {m_led, m_per, m_err, m_rdy})
        $display("FAIL rand_cycle %0d: got %b want %b", i,
                 {led, per, err, rdy}, {m_led, m_per, m_err, m_rdy});
      else n_pass++;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_chan  = 3'($urandom_range(0, 7));
      wr_duty  = 8'($urandom);
    end
    wr_valid = 0;
    enable = 1;
  endtask

  task automatic test_reset_mid();
    repeat (333) @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++;
    if ({led, oe, rdy, err, per} !== 15'h0)
      $display("FAIL mid_reset: got %h want 0", {led, oe, rdy, err, per});
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < PER + 20; i++) begin
      @(negedge clk);
      n_chk++;
      if ({led, per, rdy, oe} !== {m_led, m_per, m_rdy, 6'h3f})
        $display("FAIL post_reset: got %b want %b",
                 {led, per, rdy, oe}, {m_led, m_per, m_rdy, 6'h3f});
      else n_pass++;
    end
  endtask

  task automatic test_active_low();
    n_chk++;
    if ({led_al, oe_al} !== 12'hfff)
      $display("FAIL al_run: got %h want fff", {led_al, oe_al});
    else n_pass++;
    repeat (517) @(negedge clk);
    rst_al_n = 0;
    #1;
    n_chk++;
    if ({led_al, oe_al, rdy_al} !== 13'h1f80)
      $display("FAIL al_reset: got %h want 1f80", {led_al, oe_al, rdy_al});
    else n_pass++;
    @(negedge clk);
    rst_al_n = 1;
    @(negedge clk);
    n_chk++;
    if ({led_al, oe_al, rdy_al} !== 13'h1fff)
      $display("FAIL al_release: got %h want 1fff", {led_al, oe_al, rdy_al});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_mid_write();
    test_boundary_write();
    test_bad_chan();
    test_disable();
    test_random();
    test_reset_mid();
    test_active_low();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
